// File: rtl/ifetch_line_buffer.sv
// ---------------------------------------------------------------------------
// ifetch_line_buffer
//   Single-line instruction buffer between the fetch stage and a burst bus.
//   Holds one aligned line of LINE_WORDS 32-bit words plus its tag. A hit
//   answers in the cycle after the request. A miss fetches the whole line in
//   one burst and then delivers the requested word.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ireq              fetch request (.valid, .addr); addr held until data_ok
//   iresp             response (.addr_ok, .data_ok, .data), one-cycle pulse
//   flush             invalidate the line (fence.i / satp write)
//   mem_valid         burst request, held until the first accepted beat
//   mem_addr          line-aligned burst base address
//   mem_len           beats minus one, constant LINE_WORDS-1
//   mem_ready         beat accepted, mem_rdata valid
//   mem_rdata         beat data, ascending word order
//   mem_last          final beat of the burst
//   hit_count         requests served from the line (wraps)
//   miss_count        refills started (wraps)
// ---------------------------------------------------------------------------
package ifetch_pkg;
   typedef logic [63:0] addr_t;

   typedef struct packed {
      logic  valid;
      addr_t addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;
endpackage

module ifetch_line_buffer
   import ifetch_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned ADDR_W     = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  ibus_req_t         ireq,
   output ibus_resp_t        iresp,
   input  logic              flush,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_len,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_last,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int unsigned IDX_W = $clog2(LINE_WORDS);
   localparam int unsigned OFF_W = IDX_W + 2;
   localparam int unsigned TAG_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {IDLE, RESP, REFILL, DELIVER} state_e;

   state_e                          state_q, state_d;
   logic                            line_valid_q, line_valid_d;
   logic [TAG_W-1:0]                tag_q, tag_d;
   logic [IDX_W-1:0]                beat_q, beat_d;
   logic [TAG_W-1:0]                req_tag_q, req_tag_d;
   logic [IDX_W-1:0]                req_idx_q, req_idx_d;
   logic                            flush_pend_q, flush_pend_d;
   logic                            mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
   ibus_resp_t                      resp_q, resp_d;
   logic [31:0]                     hit_q, hit_d;
   logic [31:0]                     miss_q, miss_d;
   logic [LINE_WORDS-1:0][31:0]     words_q;

   logic [ADDR_W-1:0] in_addr;
   logic [TAG_W-1:0]  in_tag;
   logic [IDX_W-1:0]  in_idx;
   logic              is_hit;
   logic [31:0]       fill_word;
   logic              unused_addr_bits;

   assign in_addr = ireq.addr[ADDR_W-1:0];
   assign in_tag  = in_addr[ADDR_W-1:OFF_W];
   assign in_idx  = in_addr[OFF_W-1:2];
   // Byte offset (and any bits above ADDR_W) never take part in lookup.
   assign unused_addr_bits = ^ireq.addr;

   // A flush in the same cycle as a lookup forces the miss path.
   assign is_hit = line_valid_q && !flush && (tag_q == in_tag);

   // On the final beat the requested word may be the one landing this edge.
   assign fill_word = (beat_q == req_idx_q) ? mem_rdata : words_q[req_idx_q];

   always_comb begin
      state_d      = state_q;
      line_valid_d = line_valid_q;
      tag_d        = tag_q;
      beat_d       = beat_q;
      req_tag_d    = req_tag_q;
      req_idx_d    = req_idx_q;
      flush_pend_d = flush_pend_q;
      mem_valid_d  = mem_valid_q;
      mem_addr_d   = mem_addr_q;
      hit_d        = hit_q;
      miss_d       = miss_q;
      resp_d       = '0;   // response is a single-cycle pulse

      unique case (state_q)
         IDLE: begin
            if (flush) line_valid_d = 1'b0;
            if (ireq.valid) begin
               req_tag_d = in_tag;
               req_idx_d = in_idx;
               if (is_hit) begin
                  state_d        = RESP;
                  resp_d.addr_ok = 1'b1;
                  resp_d.data_ok = 1'b1;
                  resp_d.data    = words_q[in_idx];
                  hit_d          = hit_q + 32'd1;
               end else begin
                  state_d      = REFILL;
                  mem_valid_d  = 1'b1;
                  mem_addr_d   = {in_tag, {OFF_W{1'b0}}};
                  miss_d       = miss_q + 32'd1;
                  line_valid_d = 1'b0;
                  beat_d       = '0;
                  flush_pend_d = 1'b0;
               end
            end
         end

         RESP: begin
            if (flush) line_valid_d = 1'b0;
            state_d = IDLE;
         end

         REFILL: begin
            if (flush) flush_pend_d = 1'b1;
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               beat_d      = beat_q + 1'b1;
               if (mem_last) begin
                  tag_d          = req_tag_q;
                  // a flush seen anywhere in the burst keeps the line invalid
                  line_valid_d   = !(flush_pend_q || flush);
                  flush_pend_d   = 1'b0;
                  state_d        = DELIVER;
                  resp_d.addr_ok = 1'b1;
                  resp_d.data_ok = 1'b1;
                  resp_d.data    = fill_word;
               end
            end
         end

         DELIVER: begin
            if (flush) line_valid_d = 1'b0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         line_valid_q <= 1'b0;
         tag_q        <= '0;
         beat_q       <= '0;
         req_tag_q    <= '0;
         req_idx_q    <= '0;
         flush_pend_q <= 1'b0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         resp_q       <= '0;
         hit_q        <= '0;
         miss_q       <= '0;
      end else begin
         state_q      <= state_d;
         line_valid_q <= line_valid_d;
         tag_q        <= tag_d;
         beat_q       <= beat_d;
         req_tag_q    <= req_tag_d;
         req_idx_q    <= req_idx_d;
         flush_pend_q <= flush_pend_d;
         mem_valid_q  <= mem_valid_d;
         mem_addr_q   <= mem_addr_d;
         resp_q       <= resp_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
      end
   end

   // Line storage carries no reset; line_valid_q guards its use.
   always_ff @(posedge clk) begin
      if (!rst && state_q == REFILL && mem_ready) words_q[beat_q] <= mem_rdata;
   end

   assign iresp      = resp_q;
   assign mem_valid  = mem_valid_q;
   assign mem_addr   = mem_addr_q;
   assign mem_len    = 8'(LINE_WORDS - 1);
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

endmodule

// File: tb/tb_ifetch_line_buffer.sv
module tb_ifetch_line_buffer;
   import ifetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   logic        flush;
   logic        mem_valid;
   logic [63:0] mem_addr;
   logic [7:0]  mem_len;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_last;
   logic [31:0] hit_count, miss_count;

   ifetch_line_buffer #(.LINE_WORDS(4), .ADDR_W(64)) dut (
      .clk(clk), .rst(rst), .ireq(ireq), .iresp(iresp), .flush(flush),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_len(mem_len),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_last(mem_last),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: one cached line described by its base address,
   // its words, and which of those words hold known contents.
   bit          mvalid;
   logic [63:0] mbase;
   logic [31:0] mline [4];
   bit          mknown [4];
   int unsigned mhits, mmisses;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] memw(input logic [63:0] a);
      case (a)
         64'h8000_0000: return 32'h0000_0013;
         64'h8000_0004: return 32'h0010_0093;
         64'h8000_0008: return 32'h0020_0113;
         64'h8000_000C: return 32'h0030_0193;
         default:       return (a[31:0] * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
      endcase
   endfunction

   function automatic logic [63:0] aligned(input logic [63:0] a);
      return a & ~64'hF;
   endfunction

   // One complete fetch transaction. nbeats < 4 gives a short burst;
   // flush_k >= 0 pulses flush while that many beats have been accepted;
   // flush_now raises flush together with the request.
   task automatic fetch(input logic [63:0] a, input int pct, input int nbeats,
                        input int flush_k, input bit flush_now);
      logic [63:0] base;
      int          idx, done, cyc;
      bit          hit, fl, rdy;
      base = aligned(a);
      idx  = int'(a[3:2]);
      hit  = mvalid && (mbase == base) && !flush_now;
      done = 0; cyc = 0; fl = 1'b0;
      ireq.valid = 1'b1; ireq.addr = a; flush = flush_now;
      @(negedge clk);
      flush = 1'b0;
      if (hit) begin
         mhits++;
         chk("hit_data_ok", iresp.data_ok, 1);
         chk("hit_addr_ok", iresp.addr_ok, 1);
         if (mknown[idx]) chk("hit_data", iresp.data, mline[idx]);
         chk("hit_no_mem_valid", mem_valid, 0);
         ireq.valid = 1'b0;
         @(negedge clk);
         chk("hit_pulse_end", iresp.data_ok, 0);
      end else begin
         mmisses++;
         mvalid = 1'b0;
         chk("miss_mem_valid", mem_valid, 1);
         chk("miss_mem_addr", mem_addr, base);
         chk("miss_mem_len", mem_len, 3);
         chk("miss_no_resp", iresp.data_ok, 0);
         while (done < nbeats && cyc < 200) begin
            chk("refill_mem_valid", mem_valid, (done == 0) ? 1 : 0);
            rdy = ($urandom_range(0, 99) < pct);
            mem_ready = rdy;
            if (rdy) begin
               mem_rdata = memw(base + 64'(4 * done));
               mem_last  = (done == nbeats - 1);
            end else begin
               mem_rdata = $urandom;
               mem_last  = $urandom_range(0, 1) == 1;
            end
            if (flush_k == done && !fl && done < nbeats - 1) begin
               flush = 1'b1; fl = 1'b1;
            end
            @(negedge clk);
            flush = 1'b0; mem_ready = 1'b0; mem_last = 1'b0;
            if (rdy) done++;
            if (done < nbeats) chk("refill_no_resp", iresp.data_ok, 0);
            cyc++;
         end
         if (done < nbeats) chk("refill_timeout", 0, 1);
         for (int b = 0; b < nbeats; b++) begin
            mline[b]  = memw(base + 64'(4 * b));
            mknown[b] = 1'b1;
         end
         mbase  = base;
         mvalid = !fl;
         chk("deliver_data_ok", iresp.data_ok, 1);
         chk("deliver_addr_ok", iresp.addr_ok, 1);
         if (mknown[idx]) chk("deliver_data", iresp.data, mline[idx]);
         chk("deliver_mem_valid", mem_valid, 0);
         ireq.valid = 1'b0;
         @(negedge clk);
         chk("deliver_pulse_end", iresp.data_ok, 0);
      end
      chk("hit_count", hit_count, mhits);
      chk("miss_count", miss_count, mmisses);
   endtask

   task automatic model_reset();
      mvalid = 1'b0; mbase = '0; mhits = 0; mmisses = 0;
      for (int b = 0; b < 4; b++) begin
         mknown[b] = 1'b0; mline[b] = '0;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_mem_valid"}, mem_valid, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_addr_ok"}, iresp.addr_ok, 0);
      chk({tag, "_data_ok"}, iresp.data_ok, 0);
      chk({tag, "_data"}, iresp.data, 0);
      chk({tag, "_hits"}, hit_count, 0);
      chk({tag, "_misses"}, miss_count, 0);
   endtask

   initial begin
      rst = 1'b1; ireq = '0; flush = 1'b0;
      mem_ready = 1'b0; mem_rdata = '0; mem_last = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
      chk("reset_mem_len", mem_len, 3);

      // cold miss then hits on the same line
      fetch(64'h8000_0000, 100, 4, -1, 1'b0);
      fetch(64'h8000_0004, 100, 4, -1, 1'b0);
      fetch(64'h8000_0008, 100, 4, -1, 1'b0);
      fetch(64'h8000_000C, 100, 4, -1, 1'b0);
      chk("plan_hits", hit_count, 3);

      // line replacement, then the old line misses again
      fetch(64'h8000_0010, 100, 4, -1, 1'b0);
      fetch(64'h8000_0000, 100, 4, -1, 1'b0);
      chk("plan_misses", miss_count, 3);

      // flush during beat 2 of a refill: delivered, but the line stays invalid
      fetch(64'h8000_0020, 100, 4, 2, 1'b0);
      fetch(64'h8000_0024, 100, 4, -1, 1'b0);
      chk("flush_refetch_misses", miss_count, 5);

      // flush together with a hit-address request is treated as a miss
      fetch(64'h8000_0028, 100, 4, -1, 1'b1);

      // reset in the middle of a refill
      ireq.valid = 1'b1; ireq.addr = 64'h8000_0000;
      @(negedge clk);
      chk("rst_mid_mem_valid", mem_valid, 1);
      mem_ready = 1'b1; mem_rdata = memw(64'h8000_0000); mem_last = 1'b0;
      @(negedge clk);
      mem_rdata = memw(64'h8000_0004); rst = 1'b1; ireq.valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_idle_outputs("rst_mid");
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_last = 1'b0;
      @(negedge clk);
      mem_last = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0; mem_last = 1'b0;
      chk("late_beats_data_ok", iresp.data_ok, 0);
      chk("late_beats_mem_valid", mem_valid, 0);
      @(negedge clk);
      check_idle_outputs("late_beats");
      fetch(64'h8000_0000, 100, 4, -1, 1'b0);

      // held request: one pulse per accept, accepts only from idle
      begin
         int pulses = 0;
         ireq.valid = 1'b1; ireq.addr = 64'h8000_0008;
         for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            chk("hold_pulse", iresp.data_ok, (t % 2 == 1) ? 1 : 0);
            if (iresp.data_ok) begin
               pulses++;
               chk("hold_data", iresp.data, 32'h0020_0113);
            end
            if (t == 6) ireq.valid = 1'b0;
         end
         mhits += 3;
         @(negedge clk);
         chk("hold_pulses", pulses, 3);
         chk("hold_hit_count", hit_count, mhits);
      end

      // randomized traffic over four lines
      for (int it = 0; it < 60; it++) begin
         logic [63:0] a, base;
         int          idx, nb, fk, pct;
         bit          fn, miss;
         idx  = $urandom_range(0, 3);
         a    = 64'h8000_0000 + 64'($urandom_range(0, 3) * 16) + 64'(idx * 4)
                + 64'($urandom_range(0, 3));
         base = aligned(a);
         if ($urandom_range(0, 7) == 0) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            mvalid = 1'b0;
            chk("idle_flush_quiet", iresp.data_ok, 0);
         end
         fn   = ($urandom_range(0, 9) == 0);
         miss = fn || !(mvalid && mbase == base);
         nb   = (miss && $urandom_range(0, 4) == 0) ? $urandom_range(idx + 1, 4) : 4;
         fk   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
         pct  = $urandom_range(30, 100);
         fetch(a, pct, nb, fk, fn);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ifetch_line_buffer.md
Name: ifetch_line_buffer

Overview:
- Sits directly upstream of the fetch stage, between its instruction-bus port (ireq/iresp) and the memory-side burst bus.
- Holds one aligned line of LINE_WORDS instruction words with a tag.
- Hits are served in one cycle; a miss triggers one burst refill of the whole line, then the requested word is delivered.
- Also keeps hit/miss counters for performance tracking.

Parameters:
- LINE_WORDS, 4: words per line; power of two, at least 2.
- ADDR_W, 64: address width, matching addr_t.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ireq  in  ibus_req_t  fetch request; fields .valid and .addr
- iresp  out  ibus_resp_t  response; fields .addr_ok, .data_ok, .data (32 bits)
- flush  in  1  invalidate the line (fence.i, satp write)
- mem_valid  out  1  burst request valid
- mem_addr  out  ADDR_W  line-aligned burst base address
- mem_len  out  8  beats minus 1, fixed at LINE_WORDS-1
- mem_ready  in  1  one beat accepted; mem_rdata valid
- mem_rdata  in  32  beat data, ascending word order
- mem_last  in  1  final beat of the burst
- hit_count  out  32  requests served from the line
- miss_count  out  32  refills started

Behaviour:
- Reset (rst high at posedge clk): the following are all cleared to 0.
  - line_valid, tag, FSM state (IDLE), beat counter
  - mem_valid, mem_addr
  - iresp.addr_ok, iresp.data_ok, iresp.data
  - hit_count, miss_count
  - flush_pending
  - Line data contents are don't-care.
- Address split:
  - word index = addr[2+log2(LINE_WORDS)-1:2]
  - tag = addr[ADDR_W-1:2+log2(LINE_WORDS)]
  - addr[1:0] is ignored; the fetch stage traps misaligned PCs itself.
- FSM states: IDLE, RESP, REFILL, DELIVER.
- Request accept: in IDLE, ireq.valid=1 latches req_addr. The fetch stage holds addr stable until data_ok.
- Hit (line_valid and tag match) in IDLE:
  - Next state RESP.
  - In RESP: iresp.addr_ok=iresp.data_ok=1 for exactly one cycle, data=word[index]; hit_count+1; return to IDLE.
  - Latency: request seen at edge N, response visible in cycle N+1.
  - ireq.valid seen in the RESP cycle is not re-accepted until IDLE, so a held request is never double-counted.
- Miss in IDLE:
  - mem_valid=1, mem_addr = req_addr with low 2+log2(LINE_WORDS) bits cleared; miss_count+1; line_valid<=0; next REFILL.
- REFILL:
  - mem_valid stays 1 until the first mem_ready, then 0.
  - Each mem_ready writes mem_rdata into word[beat]; beat+1 wraps modulo LINE_WORDS.
  - On mem_ready&&mem_last: tag<=req tag; line_valid<=!flush_pending; flush_pending<=0; next DELIVER.
  - If mem_last arrives before beat=LINE_WORDS-1: the burst ends there, and unfilled words keep stale contents.
- DELIVER: one-cycle response pulse with word[index] (the freshly written word), then IDLE. Miss latency = burst duration + 2 cycles.
- flush:
  - In IDLE/RESP: line_valid<=0 next edge. A response already in RESP still completes with the old data.
  - In REFILL: sets flush_pending, so the current refill completes and responds but leaves line_valid=0.
  - flush and a hit request in the same IDLE cycle: flush wins and the request is treated as a miss.
- iresp.addr_ok and iresp.data_ok are always equal; never 1 outside RESP/DELIVER.
- Counters wrap at 2^32, no saturation.
- Reset mid-refill: everything returns to reset state immediately. Remaining burst beats are ignored (mem_ready outside REFILL has no effect).

Test Plan:
- Cold fetch 0x8000_0000 with memory words 0x00000013, 0x00100093, 0x00200113, 0x00300193 and mem_ready every cycle -> one burst, mem_addr=0x8000_0000, mem_len=3; response data=0x00000013; miss_count=1.
- Follow-on fetches 0x8000_0004, 0x8000_0008, 0x8000_000C -> each responds one cycle after request, data 0x00100093/0x00200113/0x00300193; hit_count=3, no mem_valid.
- Fetch 0x8000_0010 -> miss; mem_addr=0x8000_0010; then fetch 0x8000_0000 -> miss again; miss_count=3.
- flush pulsed during beat 2 of a refill for 0x8000_0020 -> response still delivered with the correct word; a re-fetch of 0x8000_0024 misses.
- rst asserted during beat 1 of a refill -> next cycle all outputs 0; late mem_ready/mem_last ignored; fetch 0x8000_0000 then misses cleanly.
- Request held across RESP with ireq.valid=1 -> exactly one data_ok pulse per accept; hit_count increments once per pulse.
